// File: rtl/mdu_iter_pkg.sv
// Shared MDU definitions: operation codes, FSM state encoding and opcode helpers.
package mdu_iter_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring-divide datapath: one shift/trial-subtract step per cycle.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;

    // Trial subtraction; a borrow in the top bit means the divisor did not fit.
    always_comb begin
        shifted_s = {rem_r, quot_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvsr_r};
    end

    // Remainder/quotient shift registers; the quotient register starts out holding the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= '0;
            quot_r <= '0;
            dvsr_r <= '0;
        end else if (load) begin
            rem_r  <= '0;
            quot_r <= dividend;
            dvsr_r <= divisor;
        end else if (step) begin
            if (diff_s[WIDTH] == 1'b0) begin
                rem_r  <= diff_s[WIDTH-1:0];
                quot_r <= {quot_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r  <= shifted_s[WIDTH-1:0];
                quot_r <= {quot_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO. Operates on magnitudes, fixes signs at the end.
// Optional: define MDU_FAST_MUL_EN for a single-cycle combinational multiply path.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_r, next_s;
    logic [CW-1:0]      cnt_r;
    logic               is_div_r, dz_r, neg_q_r, neg_rem_r, done_r;
    logic [WIDTH-1:0]   a_r, mcand_r, hi_r, lo_r;
    logic [2*WIDTH-1:0] prod_r, mul_res_s;
    logic [WIDTH-1:0]   ua_s, ub_s, quot_s, rem_s, quot_res_s, rem_res_s;
    logic               sgn_s, dz_s;
    logic [WIDTH:0]     mul_sum_s;

    // Operand magnitudes and divide-by-zero detection, valid in the start cycle.
    always_comb begin
        sgn_s = op_is_signed(op);
        ua_s  = (sgn_s && A[WIDTH-1]) ? -A : A;
        ub_s  = (sgn_s && B[WIDTH-1]) ? -B : B;
        dz_s  = op_is_div(op) && (B == '0);
    end

    // Shift-add multiply step and final sign correction of all results.
    always_comb begin
        mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        mul_res_s  = neg_q_r ? -prod_r : prod_r;
        quot_res_s = neg_q_r ? -quot_s : quot_s;
        rem_res_s  = neg_rem_r ? -rem_s : rem_s;
    end

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_r == MDU_IDLE) && start),
        .step     ((state_r == MDU_CALC) && is_div_r),
        .dividend (ua_s),
        .divisor  (ub_s),
        .quot     (quot_s),
        .rem      (rem_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; divide-by-zero (and fast multiply) bypasses CALC.
    always_comb begin
        next_s = state_r;
        case (state_r)
            MDU_IDLE: begin
                if (start) begin
                    if (dz_s) begin
                        next_s = MDU_FIX;
`ifdef MDU_FAST_MUL_EN
                    end else if (!op_is_div(op)) begin
                        next_s = MDU_FIX;
`endif
                    end else begin
                        next_s = MDU_CALC;
                    end
                end else begin
                    next_s = MDU_IDLE;
                end
            end
            MDU_CALC: begin
                if (cnt_r == CW'(WIDTH-1)) begin
                    next_s = MDU_FIX;
                end else begin
                    next_s = MDU_CALC;
                end
            end
            MDU_FIX:  next_s = MDU_IDLE;
            default:  next_s = MDU_IDLE;
        endcase
    end

    // Operation capture, iteration counter and multiply product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            is_div_r  <= 1'b0;
            dz_r      <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            a_r       <= '0;
            mcand_r   <= '0;
            prod_r    <= '0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    cnt_r <= '0;
                    if (start) begin
                        is_div_r  <= op_is_div(op);
                        dz_r      <= dz_s;
                        neg_q_r   <= sgn_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_r <= sgn_s && A[WIDTH-1];
                        a_r       <= A;
                        mcand_r   <= ua_s;
`ifdef MDU_FAST_MUL_EN
                        prod_r    <= {{WIDTH{1'b0}}, ua_s} * {{WIDTH{1'b0}}, ub_s};
`else
                        prod_r    <= {{WIDTH{1'b0}}, ub_s};
`endif
                    end
                end
                MDU_CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (!is_div_r) begin
                        prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    // HI/LO: result write in FIX, MTHI/MTLO accepted only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            case (state_r)
                MDU_FIX: begin
                    if (dz_r) begin
                        hi_r <= a_r;
                        lo_r <= {WIDTH{1'b1}};
                    end else if (is_div_r) begin
                        hi_r <= rem_res_s;
                        lo_r <= quot_res_s;
                    end else begin
                        {hi_r, lo_r} <= mul_res_s;
                    end
                end
                MDU_IDLE: begin
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                end
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end
    end

    // done pulses in the cycle after the FIX write.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == MDU_FIX);
        end
    end

    assign busy = (state_r != MDU_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: arithmetic reference model, decoupled done-monitor.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] A, B, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int t0);
        exp_t e;
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.t0  = t0;
        e.lat = W + 2;
        case (o)
            2'b00, 2'b01: begin
                if (o == 2'b00) p = sa * sb;
                else            p = ua * ub;
                e.hi = p[63:32];
                e.lo = p[31:0];
`ifdef MDU_FAST_MUL_EN
                e.lat = 2;
`endif
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.lat = 2;
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q = sq;
                    r = sr;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("hi", 64'(hi), 64'(mon_e.hi));
                chk("lo", 64'(lo), 64'(mon_e.lo));
                chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
    end

    // Drive a start pulse in the current cycle; optionally record the expected result.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op = o; A = a; B = b; start = 1'b1;
        if (push) sbq.push_back(model(o, a, b, cyc));
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 100), 64'd1);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb, rw;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; A = '0; B = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        run(2'b11, 32'h0000_0007, 32'h0000_0002);
        run(2'b11, 32'h0000_1234, 32'h0000_0000);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
        run(2'b10, 32'hFFFF_FFF0, 32'h0000_0000);
        run(2'b00, 32'h8000_0000, 32'h8000_0000);
        run(2'b00, 32'h8000_0000, 32'h0000_0001);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run(2'($urandom_range(0, 3)), ra, rb);
        end

        rw = $urandom;
        hi_we = 1'b1; wdata = rw;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'(rw));

        issue(2'b01, 32'd5, 32'd6, 1'b1);
        repeat (8) @(negedge clk);
        op = 2'b11; A = 32'd100; B = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_idle();
        lo_we = 1'b1; wdata = 32'h0000_0055;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'h55);
        chk("mtlo_hi_kept", 64'(hi), 64'd0);

        issue(2'b11, 32'd100, 32'd7, 1'b0);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        run(2'b11, 32'd100, 32'd7);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
